// File: rtl/outputport_pkg.sv
// rtl/outputport_pkg.sv - shared FSM encodings and default widths for the egress output port
package outputport_pkg;

    localparam int OP_DEFAULT_DW = 8;
    localparam int OP_DEFAULT_AW = 2;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'd0,
        OP_SETUP   = 2'd1,
        OP_WAIT_HI = 2'd2,
        OP_WAIT_LO = 2'd3
    } op_state_e;

endpackage

// File: rtl/outputport_sync2.sv
// rtl/outputport_sync2.sv - two-flop synchroniser with synchronous active-high clear
module outputport_sync2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two capture stages; the second stage is the only one used by logic downstream
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/outputport.sv
// rtl/outputport.sv - sync-to-async 4-phase bundled-data transmitter, optional watchdog under OUTPORT_TIMEOUT_EN
module outputport
    import outputport_pkg::*;
#(
    parameter int DW      = OP_DEFAULT_DW,
    parameter int AW      = OP_DEFAULT_AW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_outputport,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          req,
    input  logic          ack,
    output logic [DW-1:0] data_out,
    output logic          busy,
    output logic          err
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic ack_s;

    outputport_sync2 u_ack_sync (
        .clk_i   (clk_outputport),
        .reset_i (reset),
        .d_i     (ack),
        .q_o     (ack_s)
    );

    logic [DW-1:0] fifo_mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    op_state_e     state_q;
    logic          req_q;
    logic [DW-1:0] data_out_q;

    // The wrap bit distinguishes a full FIFO from an empty one at equal addresses
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop never frees a slot for a push in the same cycle; a stale ack_s blocks new transfers
    assign push     = in_valid && !fifo_full;
    assign pop      = (state_q == OP_IDLE) && !fifo_empty && !ack_s;
    assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // FIFO storage is written without reset; validity is tracked by the pointers alone
    always_ff @(posedge clk_outputport) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // Pointer registers; reset discards any buffered words
    always_ff @(posedge clk_outputport) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // 4-phase handshake FSM: data is loaded one cycle before req rises and held until the next load
    always_ff @(posedge clk_outputport) begin
        if (reset) begin
            state_q    <= OP_IDLE;
            req_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            case (state_q)
                OP_IDLE: begin
                    if (pop) begin
                        data_out_q <= fifo_mem_q[rd_ptr_q[AW-1:0]];
                        state_q    <= OP_SETUP;
                    end
                end
                OP_SETUP: begin
                    req_q   <= 1'b1;
                    state_q <= OP_WAIT_HI;
                end
                OP_WAIT_HI: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        state_q <= OP_WAIT_LO;
                    end
                end
                OP_WAIT_LO: begin
                    if (!ack_s) begin
                        state_q <= OP_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= OP_IDLE;
                end
            endcase
        end
    end

    assign in_ready = !fifo_full;
    assign req      = req_q;
    assign data_out = data_out_q;
    assign busy     = !fifo_empty || (state_q != OP_IDLE);

`ifdef OUTPORT_TIMEOUT_EN
    localparam int             TCW       = $clog2(TIMEOUT + 2);
    localparam logic [TCW-1:0] TMO_LIMIT = TCW'(TIMEOUT);
    localparam logic [TCW-1:0] TMO_ONE   = TCW'(1);

    logic           waiting;
    logic           state_adv;
    logic [TCW-1:0] tmo_cnt_q;
    logic [TCW-1:0] tmo_cnt_d;
    logic           err_q;

    assign waiting   = (state_q == OP_WAIT_HI) || (state_q == OP_WAIT_LO);
    assign state_adv = ((state_q == OP_WAIT_HI) && ack_s) || ((state_q == OP_WAIT_LO) && !ack_s);
    assign tmo_cnt_d = (tmo_cnt_q == TMO_LIMIT) ? tmo_cnt_q : (tmo_cnt_q + TMO_ONE);

    // Watchdog: counts cycles spent in one wait state; flags a stalled peer without aborting
    always_ff @(posedge clk_outputport) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else if (!waiting || state_adv) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_cnt_d == TMO_LIMIT) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
